// File: rtl/spi_reg_slave.sv
// ============================================================================
// spi_reg_slave : SPI slave with a parallel-readout register bank. Rev 1.0
// ============================================================================
`default_nettype none

module spi_reg_slave #(
  parameter int CMD_WIDTH  = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                                     spi_clk,
  input  logic                                     rst_n,
  input  logic                                     spi_sel,
  input  logic                                     spi_mosi,
  output logic                                     spi_miso,
  output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]    reg_data
);

  localparam int c_FRAME = CMD_WIDTH + DATA_WIDTH;
  localparam int c_NREG  = 2**ADDR_WIDTH;
  localparam int c_CNT_W = $clog2(c_FRAME + 1);

  localparam logic [c_CNT_W-1:0] c_RD_BIT = c_CNT_W'(CMD_WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_DATA0  = c_CNT_W'(CMD_WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(c_FRAME - 1);
  localparam logic [c_CNT_W-1:0] c_DONE   = c_CNT_W'(c_FRAME);

  // Frame state is held clear whenever the slave is deselected or in reset.
  logic w_clr;
  assign w_clr = ~rst_n | spi_sel;

  logic [c_CNT_W-1:0]             cnt_q,  cnt_d;
  logic [c_FRAME-2:0]             sin_q,  sin_d;
  logic [DATA_WIDTH-1:0]          sout_q, sout_d;
  logic                           rd_q,   rd_d;
  logic                           miso_q, miso_d;
  logic [c_NREG*DATA_WIDTH-1:0]   regs_q, regs_d;

  logic [c_FRAME-1:0]             w_frame;
  logic [CMD_WIDTH-1:0]           w_cmd;
  logic [ADDR_WIDTH-1:0]          w_rd_addr;
  logic [ADDR_WIDTH-1:0]          w_wr_addr;
  logic                           w_rd_load;
  logic                           w_wr_en;

  // Bits sampled so far plus the one being sampled on this falling edge.
  assign w_frame   = {sin_q, spi_mosi};
  assign w_cmd     = w_frame[CMD_WIDTH-1:0];
  assign w_rd_addr = w_cmd[CMD_WIDTH-2 -: ADDR_WIDTH];
  assign w_wr_addr = w_frame[c_FRAME-2 -: ADDR_WIDTH];
  assign w_rd_load = (cnt_q == c_RD_BIT) && !w_cmd[CMD_WIDTH-1];
  assign w_wr_en   = !spi_sel && (cnt_q == c_LAST) && w_frame[c_FRAME-1];

  always_comb begin
    cnt_d  = cnt_q;
    sin_d  = sin_q;
    sout_d = sout_q;
    rd_d   = rd_q;
    regs_d = regs_q;
    // Counter saturates after the last bit so extra clocks are ignored.
    if (cnt_q != c_DONE) begin
      cnt_d = cnt_q + 1'b1;
      sin_d = w_frame[c_FRAME-2:0];
    end
    if (w_rd_load) begin
      sout_d = regs_q[w_rd_addr*DATA_WIDTH +: DATA_WIDTH];
      rd_d   = 1'b1;
    end else if (rd_q) begin
      sout_d = {sout_q[DATA_WIDTH-2:0], 1'b0};
    end
    if (w_wr_en) begin
      regs_d[w_wr_addr*DATA_WIDTH +: DATA_WIDTH] = w_frame[DATA_WIDTH-1:0];
    end
    miso_d = (rd_q && (cnt_q >= c_DATA0) && (cnt_q < c_DONE)) ?
             sout_q[DATA_WIDTH-1] : 1'b0;
  end

  always_ff @(negedge spi_clk or posedge w_clr) begin
    if (w_clr) begin
      cnt_q  <= '0;
      sin_q  <= '0;
      sout_q <= '0;
      rd_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sin_q  <= sin_d;
      sout_q <= sout_d;
      rd_q   <= rd_d;
    end
  end

  // MISO launches on the rising edge so the master sees it stable at sampling.
  always_ff @(posedge spi_clk or posedge w_clr) begin
    if (w_clr) begin
      miso_q <= 1'b0;
    end else begin
      miso_q <= miso_d;
    end
  end

  always_ff @(negedge spi_clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign spi_miso = miso_q;
  assign reg_data = regs_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_slave.sv
// ============================================================================
// tb_spi_reg_slave : directed self-checking bench for spi_reg_slave. Rev 1.0
// ============================================================================
`default_nettype none

module tb_spi_reg_slave;

  logic        spi_clk;
  logic        rst_n;
  logic        spi_sel;
  logic        spi_mosi;
  logic        spi_miso;
  logic [63:0] reg_data;

  int checks = 0;
  int errors = 0;

  spi_reg_slave #(
    .CMD_WIDTH  (8),
    .DATA_WIDTH (8),
    .ADDR_WIDTH (3)
  ) dut (
    .spi_clk  (spi_clk),
    .rst_n    (rst_n),
    .spi_sel  (spi_sel),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .reg_data (reg_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One select window of nclk bits; cap[31-i] holds MISO seen during bit i.
  task automatic frame(input logic [15:0] f, input int nclk, output logic [31:0] cap);
    cap = '0;
    spi_sel = 1'b0;
    #5;
    for (int i = 0; i < nclk; i++) begin
      spi_clk = 1'b1;
      #3;
      if (i < 32) cap[31-i] = spi_miso;
      #2;
      spi_mosi = (i < 16) ? f[15-i] : 1'b1;
      #5;
      spi_clk = 1'b0;
      #5;
    end
    spi_sel  = 1'b1;
    spi_mosi = 1'b0;
    #10;
  endtask

  logic [31:0] cap;
  logic [15:0] fr;

  initial begin
    spi_clk  = 1'b0;
    rst_n    = 1'b0;
    spi_sel  = 1'b1;
    spi_mosi = 1'b0;
    #20;
    chk("reset_regs", reg_data, 64'h0);
    chk("reset_miso", {63'h0, spi_miso}, 64'h0);
    rst_n = 1'b1;
    #10;

    // Write 0x6A to reg 7
    frame(16'hF06A, 16, cap);
    chk("wr7_regs", reg_data, 64'h6A00_0000_0000_0000);
    chk("wr7_miso_quiet", {32'h0, cap}, 64'h0);

    // Read reg 7: command phase quiet, data MSB first
    frame(16'h7000, 16, cap);
    chk("rd7_miso", {48'h0, cap[31:16]}, 64'h0000_0000_0000_006A);
    chk("rd7_regs_kept", reg_data, 64'h6A00_0000_0000_0000);

    // Aborted write to reg 2 after 10 bits, then a full one
    frame(16'hA0FF, 10, cap);
    chk("abort_regs", reg_data, 64'h6A00_0000_0000_0000);
    frame(16'hA055, 16, cap);
    chk("wr2_regs", reg_data, 64'h6A00_0000_0055_0000);

    // Write reg 0 with pad 1111 and 20 clocks in one select
    frame(16'h8FA5, 20, cap);
    chk("wr0_pad_regs", reg_data, 64'h6A00_0000_0055_00A5);

    // Read reg 2 with 20 clocks: trailing bits stay 0
    frame(16'h2000, 20, cap);
    chk("rd2_miso", {48'h0, cap[31:16]}, 64'h0000_0000_0000_0055);
    chk("rd2_tail_quiet", {60'h0, cap[15:12]}, 64'h0);

    // Reset in the middle of a read of reg 7
    fr = 16'h7000;
    spi_sel = 1'b0;
    #5;
    for (int i = 0; i < 10; i++) begin
      spi_clk = 1'b1;
      #5;
      spi_mosi = fr[15-i];
      #5;
      spi_clk = 1'b0;
      #10;
    end
    spi_clk = 1'b1;
    #3;
    chk("midread_miso_bit10", {63'h0, spi_miso}, 64'h1);
    rst_n = 1'b0;
    #2;
    chk("midrst_miso", {63'h0, spi_miso}, 64'h0);
    chk("midrst_regs", reg_data, 64'h0);
    spi_clk = 1'b0;
    #5;
    rst_n    = 1'b1;
    spi_sel  = 1'b1;
    spi_mosi = 1'b0;
    #10;
    frame(16'hF06A, 16, cap);
    chk("post_rst_wr7", reg_data, 64'h6A00_0000_0000_0000);

    // Write 0x01..0x08 to regs 0..7, then read each back
    for (int a = 0; a < 8; a++) begin
      fr = {1'b1, 3'(a), 4'h0, 8'(a + 1)};
      frame(fr, 16, cap);
    end
    chk("wr_all_regs", reg_data, 64'h0807_0605_0403_0201);
    for (int a = 0; a < 8; a++) begin
      fr = {1'b0, 3'(a), 12'h000};
      frame(fr, 16, cap);
      chk($sformatf("rd_all_%0d", a), {48'h0, cap[31:16]}, 64'(a + 1));
    end

    // Clocks while deselected have no effect
    spi_sel = 1'b1;
    for (int i = 0; i < 20; i++) begin
      spi_mosi = 1'b1;
      spi_clk  = 1'b1;
      #5;
      chk("desel_miso", {63'h0, spi_miso}, 64'h0);
      spi_clk = 1'b0;
      #5;
    end
    spi_mosi = 1'b0;
    chk("desel_regs", reg_data, 64'h0807_0605_0403_0201);

    // Deselected clocks left the counter at 0: a fresh read is aligned
    frame(16'h5000, 16, cap);
    chk("rd5_after_desel", {48'h0, cap[31:16]}, 64'h0000_0000_0000_0006);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
